// File: rtl/reset_seq_ctrl.sv
// reset_seq_ctrl: central reset sequencer.
//
// This block combines the power-on reset and N_REQ level reset requests into one
// reset sequence. All domains are held in reset for HOLD_CYC quiet cycles. The
// domains are then released one at a time, starting at bit 0, with STAGGER_CYC
// cycles between releases. The block also records which requesters caused a
// reset, and counts the request-triggered sequences.
//
// Ports:
//   clk        single clock
//   rst        synchronous active-high power-on reset
//   req_i      [N_REQ] level reset requests, active-high
//   req_en     [N_REQ] per-requester enable mask
//   cause_clr  clears the sticky cause register (new requests still set bits)
//   dom_rst    [N_DOM] per-domain reset, active-high, registered
//   in_reset   high while any dom_rst bit is high, registered
//   cause      [N_REQ] sticky record of requesters that fired
//   seq_cnt    [8] number of request-triggered sequences, saturating at 255

// One domain's reset flop. The flop is set by rst or by a restart. It clears on
// a release step, but only after every lower domain has been released. Only one
// cell can see prev_rel high while it is still set, so each step releases
// exactly one domain, and the release order is always bit 0 first.
module reset_seq_dom (
  input  logic clk,
  input  logic rst,
  input  logic assert_all,
  input  logic step,
  input  logic prev_rel,
  output logic dom_rst
);

  always_ff @(posedge clk) begin
    if (rst || assert_all)       dom_rst <= 1'b1;
    else if (step && prev_rel)   dom_rst <= 1'b0;
  end

endmodule

module reset_seq_ctrl #(
  parameter int N_REQ       = 4,
  parameter int N_DOM       = 3,
  parameter int HOLD_CYC    = 16,
  parameter int STAGGER_CYC = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] req_en,
  input  logic             cause_clr,
  output logic [N_DOM-1:0] dom_rst,
  output logic             in_reset,
  output logic [N_REQ-1:0] cause,
  output logic [7:0]       seq_cnt
);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  // The step that sees only this bit still set is the last release.
  localparam logic [N_DOM-1:0] DOM_LAST = N_DOM'(1) << (N_DOM - 1);
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] STAG_END = CNT_W'(STAGGER_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_REQ-1:0] act;
  logic             any_act;
  logic             step;        // release the next domain at this edge
  logic             assert_all;  // restart: reassert every domain at this edge
  logic             inc_seq;

  assign act     = req_i & req_en;
  assign any_act = |act;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    step       = 1'b0;
    assert_all = 1'b0;
    inc_seq    = 1'b0;
    case (state)
      S_HOLD: begin
        // Any active request restarts the quiet-time count. The hold ends on
        // the edge where the count has already reached HOLD_CYC, which is
        // HOLD_CYC edges after the first quiet edge.
        if (any_act) begin
          cnt_nxt = '0;
        end else if (cnt == HOLD_END) begin
          step      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = (dom_rst == DOM_LAST) ? S_RUN : S_RELEASE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (any_act) begin
          assert_all = 1'b1;
          inc_seq    = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = S_HOLD;
        end else if (cnt == STAG_END) begin
          step      = 1'b1;
          cnt_nxt   = '0;
          if (dom_rst == DOM_LAST) state_nxt = S_RUN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (any_act) begin
          assert_all = 1'b1;
          inc_seq    = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = S_HOLD;
        end
      end
      default: begin
        assert_all = 1'b1;
        cnt_nxt    = '0;
        state_nxt  = S_HOLD;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters, status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_HOLD;
      cnt      <= '0;
      in_reset <= 1'b1;
      cause    <= '0;
      seq_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      // All domains are released exactly when the FSM enters RUN.
      in_reset <= (state_nxt != S_RUN);
      // A new request wins over a clear for its own bits.
      cause    <= (cause_clr ? '0 : cause) | act;
      if (inc_seq && (seq_cnt != 8'hFF)) seq_cnt <= seq_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-domain reset flops
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < N_DOM; k++) begin : g_dom
    logic prev_rel;
    if (k == 0) begin : g_first
      assign prev_rel = 1'b1;
    end else begin : g_rest
      assign prev_rel = ~dom_rst[k-1];
    end

    reset_seq_dom u_dom (
      .clk        (clk),
      .rst        (rst),
      .assert_all (assert_all),
      .step       (step),
      .prev_rel   (prev_rel),
      .dom_rst    (dom_rst[k])
    );
  end

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed testbench for reset_seq_ctrl with the default parameters
// (4 requesters, 3 domains, hold of 16 cycles, stagger of 4 cycles).
// Inputs change 1 time unit after the rising edge. Outputs are checked at
// that same point, so each check shows the state after the edge just taken.
module tb_reset_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i;
  logic [3:0] req_en;
  logic       cause_clr;
  logic [2:0] dom_rst;
  logic       in_reset;
  logic [3:0] cause;
  logic [7:0] seq_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reset_seq_ctrl #(
    .N_REQ(4), .N_DOM(3), .HOLD_CYC(16), .STAGGER_CYC(4), .CNT_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .req_en    (req_en),
    .cause_clr (cause_clr),
    .dom_rst   (dom_rst),
    .in_reset  (in_reset),
    .cause     (cause),
    .seq_cnt   (seq_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Call this when the next edge is E0, with the inputs quiet. It walks through
  // the full 16/4/4 sequence and leaves the block in RUN (after edge E0+24).
  task automatic chk_release(input string tag);
    tick(16);
    chk({tag, " hold@E0+15"},  {29'd0, dom_rst}, 32'b111);
    chk({tag, " inrst@E0+15"}, {31'd0, in_reset}, 32'd1);
    tick(1);
    chk({tag, " rel0@E0+16"},  {29'd0, dom_rst}, 32'b110);
    tick(3);
    chk({tag, " rel0@E0+19"},  {29'd0, dom_rst}, 32'b110);
    tick(1);
    chk({tag, " rel1@E0+20"},  {29'd0, dom_rst}, 32'b100);
    tick(3);
    chk({tag, " rel1@E0+23"},  {29'd0, dom_rst}, 32'b100);
    chk({tag, " inrst@E0+23"}, {31'd0, in_reset}, 32'd1);
    tick(1);
    chk({tag, " run@E0+24"},   {29'd0, dom_rst}, 32'b000);
    chk({tag, " inrst@E0+24"}, {31'd0, in_reset}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_i = '0; req_en = 4'hF; cause_clr = 1'b0;
    #1;

    // Power-on reset
    tick(5);
    chk("por dom",   {29'd0, dom_rst}, 32'b111);
    chk("por inrst", {31'd0, in_reset}, 32'd1);
    chk("por cause", {28'd0, cause}, 32'd0);
    chk("por seq",   {24'd0, seq_cnt}, 32'd0);
    rst = 1'b0;
    chk_release("por");
    chk("por cause end", {28'd0, cause}, 32'd0);
    chk("por seq end",   {24'd0, seq_cnt}, 32'd0);

    // Single-cycle request while in RUN
    req_i = 4'b0100;
    tick(1);
    req_i = '0;
    chk("runreq dom",   {29'd0, dom_rst}, 32'b111);
    chk("runreq inrst", {31'd0, in_reset}, 32'd1);
    chk("runreq cause", {28'd0, cause}, 32'b0100);
    chk("runreq seq",   {24'd0, seq_cnt}, 32'd1);
    chk_release("runreq");

    // Clearing the cause leaves seq_cnt alone
    cause_clr = 1'b1;
    tick(1);
    cause_clr = 1'b0;
    chk("clr cause", {28'd0, cause}, 32'd0);
    chk("clr seq",   {24'd0, seq_cnt}, 32'd1);

    // A masked request held for a long time has no effect
    req_en = 4'b1011;
    req_i  = 4'b0100;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("masked dom", {29'd0, dom_rst}, 32'b000);
    end
    chk("masked inrst", {31'd0, in_reset}, 32'd0);
    chk("masked cause", {28'd0, cause}, 32'd0);
    chk("masked seq",   {24'd0, seq_cnt}, 32'd1);

    // An enabled request held for 30 edges (T..T+29) stretches HOLD
    req_i = 4'b0001;
    tick(1);
    chk("held dom@T",   {29'd0, dom_rst}, 32'b111);
    chk("held seq@T",   {24'd0, seq_cnt}, 32'd2);
    tick(29);
    req_i = '0;
    chk("held dom@T+29", {29'd0, dom_rst}, 32'b111);
    chk("held seq@T+29", {24'd0, seq_cnt}, 32'd2);
    chk("held cause",    {28'd0, cause}, 32'b0001);
    chk_release("held");

    // A request on the same edge as cause_clr keeps its own bit
    req_en    = 4'hF;
    cause_clr = 1'b1;
    req_i     = 4'b0010;
    tick(1);
    cause_clr = 1'b0;
    req_i     = '0;
    chk("clrreq cause", {28'd0, cause}, 32'b0010);
    chk("clrreq seq",   {24'd0, seq_cnt}, 32'd3);

    // rst while in RELEASE with dom_rst = 100
    tick(21);
    chk("midrst pre dom", {29'd0, dom_rst}, 32'b100);
    chk("midrst pre seq", {24'd0, seq_cnt}, 32'd3);
    rst = 1'b1;
    tick(1);
    chk("midrst dom",   {29'd0, dom_rst}, 32'b111);
    chk("midrst inrst", {31'd0, in_reset}, 32'd1);
    chk("midrst cause", {28'd0, cause}, 32'd0);
    chk("midrst seq",   {24'd0, seq_cnt}, 32'd0);
    rst = 1'b0;
    chk_release("midrst");

    // Restart from RELEASE when dom_rst = 110
    req_i = 4'b0001;
    tick(1);
    req_i = '0;
    tick(17);
    chk("rstrt pre dom", {29'd0, dom_rst}, 32'b110);
    req_i = 4'b1000;
    tick(1);
    req_i = '0;
    chk("rstrt dom",   {29'd0, dom_rst}, 32'b111);
    chk("rstrt inrst", {31'd0, in_reset}, 32'd1);
    chk("rstrt cause", {28'd0, cause}, 32'b1001);
    chk("rstrt seq",   {24'd0, seq_cnt}, 32'd2);
    chk_release("rstrt");

    // Saturation: 260 requests issued from RUN, each followed by a full sequence
    for (int i = 0; i < 260; i++) begin
      req_i = 4'b0001;
      tick(1);
      req_i = '0;
      tick(25);
      if (i == 251) chk("sat seq 254", {24'd0, seq_cnt}, 32'd254);
      if (i == 252) chk("sat seq 255", {24'd0, seq_cnt}, 32'd255);
    end
    chk("sat seq hold", {24'd0, seq_cnt}, 32'd255);
    chk("sat dom run",  {29'd0, dom_rst}, 32'b000);
    cause_clr = 1'b1;
    tick(1);
    cause_clr = 1'b0;
    chk("sat clr cause", {28'd0, cause}, 32'd0);
    chk("sat clr seq",   {24'd0, seq_cnt}, 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/reset_seq_ctrl.md
Name: reset_seq_ctrl

Overview:
- Central reset controller for the SoC testbench/RTL.
- Merges a power-on reset and N_REQ reset requesters (SW, watchdog, debug, external) into one sequenced reset event.
- Drives N_DOM per-domain resets, each in the same form a domain's reset interface consumes.
- Holds all domains in reset for a minimum time, then releases them one by one in a fixed order with a programmable stagger, and records which requesters caused the last sequence.

Parameters:
- N_REQ, 4, number of reset requesters.
- N_DOM, 3, number of reset domains; bit 0 is released first. Must be ≥ 1.
- HOLD_CYC, 16, minimum cycles all domains are held in reset. Must be ≥ 1.
- STAGGER_CYC, 4, cycles between successive domain releases. Must be ≥ 1.
- CNT_W, 8, width of the internal hold/stagger counter. Must hold max(HOLD_CYC, STAGGER_CYC).

Ports:
- clk  input  1  single clock for the whole block.
- rst  input  1  synchronous, active-high reset (power-on reset).
- req_i  input  N_REQ  level reset requests, active-high.
- req_en  input  N_REQ  per-requester enable mask.
- cause_clr  input  1  clears the cause register.
- dom_rst  output  N_DOM  per-domain reset, active-high, registered.
- in_reset  output  1  high while any dom_rst bit is high.
- cause  output  N_REQ  sticky record of the requesters that triggered reset.
- seq_cnt  output  8  count of request-triggered sequences, saturating at 255.

Behaviour:
- One clock domain. One synchronous, active-high reset `rst`. All outputs are registered.
- Active request: act = req_i & req_en. A request is "active" when |act = 1.
- While rst = 1 (sampled at the edge):
  - dom_rst = all ones, in_reset = 1, cause = 0, seq_cnt = 0.
  - State = HOLD, counter = 0.
  - rst overrides everything, including mid-sequence.
- States: HOLD, RELEASE, RUN.
- HOLD:
  - dom_rst = all ones.
  - The counter increments only on edges where rst = 0 and no request is active; an active request forces counter = 0.
  - Define E0 as the first edge in HOLD with rst = 0 and no active request.
  - dom_rst[0] goes low at edge E0+HOLD_CYC. State → RELEASE, counter = 0.
- RELEASE:
  - dom_rst[k] goes low at edge E0 + HOLD_CYC + k*STAGGER_CYC. Released bits stay low.
  - in_reset goes low at the same edge as dom_rst[N_DOM-1]; state → RUN at that edge.
  - For N_DOM = 1, the HOLD→RELEASE edge also enters RUN.
- RUN:
  - dom_rst = 0, in_reset = 0.
  - An active request at edge T sets dom_rst = all ones and in_reset = 1 at T, and the state goes to HOLD with counter = 0.
- Restart: an active request sampled in RELEASE behaves exactly as in RUN. All bits are reasserted at that edge and the full sequence replays.
- Requests in HOLD only extend HOLD; they do not restart or count.
- cause:
  - cause <= (cause_clr ? 0 : cause) | act on every edge with rst = 0, in any state.
  - A new request in the same cycle as cause_clr wins for its own bits.
- seq_cnt: increments by 1 on each RUN→HOLD or RELEASE→HOLD transition. It saturates at 255 and is not affected by cause_clr.
- Masked bits (req_en = 0) have no effect on state or cause.
- Glitch-free: each dom_rst bit changes at most once per edge. No bit is released out of order.

Test Plan:
- Power-on: rst = 1 for 5 cycles, then 0; E0 = first edge with rst sampled 0 → dom_rst = 111 until E0+16; then 110 at E0+16, 100 at E0+20, 000 with in_reset = 0 at E0+24; cause = 0, seq_cnt = 0.
- RUN request: req_en = 4'hF, single-cycle req_i = 4'b0100 at edge T → at T dom_rst = 111, cause = 0100, seq_cnt = 1; E0 = T+1; dom_rst = 110 at T+17, 100 at T+21, 000 at T+25.
- Masked and held: req_en = 4'b1011, req_i = 4'b0100 held 50 cycles → no output change. Then req_i = 4'b0001 held from T through T+29 → dom_rst = 111 through T+29+16; first release at T+30+16.
- Restart in RELEASE: when dom_rst = 110, pulse req_i[3] → next edge dom_rst = 111, cause |= 1000, seq_cnt increments; the full 16/4/4 sequence replays from the new E0.
- Cause/saturation: cause = 0101 in RUN, with cause_clr = 1 and req_i = 0010 on the same edge → cause = 0010. 260 RUN requests → seq_cnt = 255.
- Reset mid-sequence: assert rst during RELEASE with dom_rst = 100 and seq_cnt = 3 → next edge dom_rst = 111, cause = 0, seq_cnt = 0; the power-on sequence replays after rst drops.
